// File: rtl/cdb_pkg.sv
// Shared types and sizing for the CDB transmit side.
// Optional rotating-priority arbitration is enabled by defining CDB_ROUND_ROBIN_EN.
package cdb_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned ROB_TAG_WIDTH = 4;
  localparam int unsigned ROB_BUF_SIZE  = 16;
  localparam int unsigned N_PORTS       = 4;
  localparam int unsigned PORT_IDX_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  localparam int unsigned CDB_PORT_ALU    = 0;
  localparam int unsigned CDB_PORT_BRANCH = 1;
  localparam int unsigned CDB_PORT_LOAD   = 2;

  typedef struct packed {
    logic [XLEN-1:0]          data;
    logic [ROB_TAG_WIDTH-1:0] rob_tag;
    logic                     exception;
    logic                     branch_mispredict;
  } cdb_packet_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter. With CDB_ROUND_ROBIN_EN defined the search starts at i_ptr
// and wraps; otherwise the lowest requesting index wins and there is no pointer input.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
`ifdef CDB_ROUND_ROBIN_EN
  input  logic [IdxW-1:0] i_ptr,
`endif
  output logic [N-1:0]    o_grant
);

  logic w_found;

`ifdef CDB_ROUND_ROBIN_EN
  logic [IdxW-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = IdxW'((32'(i_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end
`else
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!w_found && i_req[k]) begin
        o_grant[k] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit side: per-port one-entry holding buffers, flush filtering, one registered
// broadcast per cycle. Define CDB_ROUND_ROBIN_EN for rotating priority (else fixed priority).
module cdb_arbiter
  import cdb_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [N_PORTS-1:0]                     req_valid,
  output logic [N_PORTS-1:0]                     req_ready,
  input  logic [N_PORTS-1:0][XLEN-1:0]           req_data,
  input  logic [N_PORTS-1:0][ROB_TAG_WIDTH-1:0]  req_rob_tag,
  input  logic [N_PORTS-1:0]                     req_exception,
  input  logic [N_PORTS-1:0]                     req_branch_mispredict,
  input  logic [ROB_BUF_SIZE-1:0]                flush,
  output logic                                   cdb_valid,
  output logic [XLEN-1:0]                        cdb_data,
  output logic [ROB_TAG_WIDTH-1:0]               cdb_rob_tag,
  output logic                                   cdb_exception,
  output logic                                   branch_mispredict,
  output logic [N_PORTS-1:0]                     held_valid
);

  cdb_packet_t [N_PORTS-1:0] r_held;
  logic [N_PORTS-1:0]        r_held_valid;
  cdb_packet_t               r_cdb;
  logic                      r_cdb_valid;

  logic [N_PORTS-1:0]    w_flush_held;
  logic [N_PORTS-1:0]    w_eligible;
  logic [N_PORTS-1:0]    w_grant;
  logic [N_PORTS-1:0]    w_store;
  logic [PORT_IDX_W-1:0] w_grant_idx;
  logic                  w_any_grant;

  always_comb begin
    w_flush_held = '0;
    w_eligible   = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      w_flush_held[p] = flush[r_held[p].rob_tag];
      w_eligible[p]   = r_held_valid[p] & ~w_flush_held[p];
    end
  end

`ifdef CDB_ROUND_ROBIN_EN
  logic [PORT_IDX_W-1:0] r_rr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_any_grant) begin
      r_rr_ptr <= (w_grant_idx == PORT_IDX_W'(N_PORTS - 1)) ? '0 : w_grant_idx + 1'b1;
    end
  end
`endif

  rr_arbiter #(
    .N (N_PORTS)
  ) u_arb (
    .i_req   (w_eligible),
`ifdef CDB_ROUND_ROBIN_EN
    .i_ptr   (r_rr_ptr),
`endif
    .o_grant (w_grant)
  );

  // A granted port may refill in the same cycle it drains; a flushed request is consumed.
  always_comb begin
    req_ready   = '0;
    w_store     = '0;
    w_grant_idx = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      req_ready[p] = ~r_held_valid[p] | w_grant[p];
      w_store[p]   = req_valid[p] & req_ready[p] & ~flush[req_rob_tag[p]];
      if (w_grant[p]) w_grant_idx = PORT_IDX_W'(p);
    end
    w_any_grant = |w_grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_held_valid <= '0;
      r_cdb_valid  <= 1'b0;
      r_cdb        <= '0;
    end else begin
      r_cdb_valid <= w_any_grant;
      r_cdb       <= w_any_grant ? r_held[w_grant_idx] : '0;
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        if (w_store[p]) begin
          r_held_valid[p] <= 1'b1;
        end else if (w_grant[p] || w_flush_held[p]) begin
          r_held_valid[p] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (w_store[p]) begin
        r_held[p] <= '{data:              req_data[p],
                       rob_tag:           req_rob_tag[p],
                       exception:         req_exception[p],
                       branch_mispredict: req_branch_mispredict[p]};
      end
    end
  end

  assign cdb_valid         = r_cdb_valid;
  assign cdb_data          = r_cdb.data;
  assign cdb_rob_tag       = r_cdb.rob_tag;
  assign cdb_exception     = r_cdb.exception;
  assign branch_mispredict = r_cdb.branch_mispredict;
  assign held_valid        = r_held_valid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural model (honours CDB_ROUND_ROBIN_EN).
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic                                  clk = 1'b0;
  logic                                  reset;
  logic [N_PORTS-1:0]                    req_valid;
  logic [N_PORTS-1:0]                    req_ready;
  logic [N_PORTS-1:0][XLEN-1:0]          req_data;
  logic [N_PORTS-1:0][ROB_TAG_WIDTH-1:0] req_rob_tag;
  logic [N_PORTS-1:0]                    req_exception;
  logic [N_PORTS-1:0]                    req_branch_mispredict;
  logic [ROB_BUF_SIZE-1:0]               flush;
  logic                                  cdb_valid;
  logic [XLEN-1:0]                       cdb_data;
  logic [ROB_TAG_WIDTH-1:0]              cdb_rob_tag;
  logic                                  cdb_exception;
  logic                                  branch_mispredict;
  logic [N_PORTS-1:0]                    held_valid;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk                   (clk),
    .reset                 (reset),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_data              (req_data),
    .req_rob_tag           (req_rob_tag),
    .req_exception         (req_exception),
    .req_branch_mispredict (req_branch_mispredict),
    .flush                 (flush),
    .cdb_valid             (cdb_valid),
    .cdb_data              (cdb_data),
    .cdb_rob_tag           (cdb_rob_tag),
    .cdb_exception         (cdb_exception),
    .branch_mispredict     (branch_mispredict),
    .held_valid            (held_valid)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Model: one slot per port, plus the expected broadcast after the coming edge.
  logic                     m_valid [N_PORTS];
  logic [XLEN-1:0]          m_data  [N_PORTS];
  logic [ROB_TAG_WIDTH-1:0] m_tag   [N_PORTS];
  logic                     m_exc   [N_PORTS];
  logic                     m_mis   [N_PORTS];
`ifdef CDB_ROUND_ROBIN_EN
  int                       m_ptr = 0;
`endif
  logic                     e_valid = 1'b0;
  logic [XLEN-1:0]          e_data  = '0;
  logic [ROB_TAG_WIDTH-1:0] e_tag   = '0;
  logic                     e_exc   = 1'b0;
  logic                     e_mis   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Evaluates the model for the current inputs and advances it past the coming edge.
  task automatic model_step();
    int                 winner;
    int                 p;
    logic [N_PORTS-1:0] rdy;
    winner = -1;
    for (int k = 0; k < N_PORTS; k++) begin
`ifdef CDB_ROUND_ROBIN_EN
      p = (m_ptr + k) % N_PORTS;
`else
      p = k;
`endif
      if (winner < 0 && m_valid[p] && !flush[m_tag[p]]) winner = p;
    end
    for (int q = 0; q < N_PORTS; q++) rdy[q] = !m_valid[q] || (winner == q);
    if (!reset) chk("req_ready", 64'(req_ready), 64'(rdy));

    if (reset) begin
      for (int q = 0; q < N_PORTS; q++) m_valid[q] = 1'b0;
      {e_valid, e_data, e_tag, e_exc, e_mis} = '0;
`ifdef CDB_ROUND_ROBIN_EN
      m_ptr = 0;
`endif
    end else begin
      if (winner >= 0) begin
        e_valid = 1'b1;
        e_data  = m_data[winner];
        e_tag   = m_tag[winner];
        e_exc   = m_exc[winner];
        e_mis   = m_mis[winner];
`ifdef CDB_ROUND_ROBIN_EN
        m_ptr = (winner + 1) % N_PORTS;
`endif
      end else begin
        {e_valid, e_data, e_tag, e_exc, e_mis} = '0;
      end
      for (int q = 0; q < N_PORTS; q++) begin
        if (winner == q || flush[m_tag[q]]) m_valid[q] = 1'b0;
        if (req_valid[q] && rdy[q] && !flush[req_rob_tag[q]]) begin
          m_valid[q] = 1'b1;
          m_data[q]  = req_data[q];
          m_tag[q]   = req_rob_tag[q];
          m_exc[q]   = req_exception[q];
          m_mis[q]   = req_branch_mispredict[q];
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [N_PORTS-1:0] hv;
    for (int q = 0; q < N_PORTS; q++) hv[q] = m_valid[q];
    chk("cdb_valid", 64'(cdb_valid), 64'(e_valid));
    chk("cdb_data", 64'(cdb_data), 64'(e_data));
    chk("cdb_rob_tag", 64'(cdb_rob_tag), 64'(e_tag));
    chk("cdb_exception", 64'(cdb_exception), 64'(e_exc));
    chk("branch_mispredict", 64'(branch_mispredict), 64'(e_mis));
    chk("held_valid", 64'(held_valid), 64'(hv));
  endtask

  // Inputs are driven at the negedge; the model runs before the edge, outputs checked after.
  task automatic tick();
    #1;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clr();
    req_valid             = '0;
    req_exception         = '0;
    req_branch_mispredict = '0;
    flush                 = '0;
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int q = 0; q < N_PORTS; q++) begin
      m_valid[q] = 1'b0;
      m_data[q]  = '0;
      m_tag[q]   = '0;
      m_exc[q]   = 1'b0;
      m_mis[q]   = 1'b0;
    end
    req_data    = '0;
    req_rob_tag = '0;
    clr();
    reset = 1'b1;
    @(negedge clk);
    do_reset();

    // Single result from port 0: two-cycle latency, one-cycle broadcast.
    chk("s1_rst_cdb_valid", 64'(cdb_valid), 64'(0));
    chk("s1_rst_held", 64'(held_valid), 64'(0));
    #1;
    chk("s1_rst_ready", 64'(req_ready), 64'(4'hF));
    req_valid[0]   = 1'b1;
    req_data[0]    = 32'h7867_5645;
    req_rob_tag[0] = 4'd0;
    tick();
    clr();
    chk("s1_e0_cdb_valid", 64'(cdb_valid), 64'(0));
    chk("s1_e0_held", 64'(held_valid), 64'(4'b0001));
    tick();
    chk("s1_bc_valid", 64'(cdb_valid), 64'(1));
    chk("s1_bc_data", 64'(cdb_data), 64'(32'h7867_5645));
    chk("s1_bc_tag", 64'(cdb_rob_tag), 64'(0));
    chk("s1_bc_held", 64'(held_valid), 64'(0));
    tick();
    chk("s1_after_valid", 64'(cdb_valid), 64'(0));

    // Three ports at once: broadcast order tag 3, 4, 5.
    do_reset();
    req_valid = 4'b0111;
    for (int q = 0; q < 3; q++) begin
      req_rob_tag[q] = ROB_TAG_WIDTH'(3 + q);
      req_data[q]    = XLEN'(32'hA000 + q);
    end
    tick();
    clr();
    for (int t = 3; t <= 5; t++) begin
      tick();
      chk("s2_valid", 64'(cdb_valid), 64'(1));
      chk("s2_tag", 64'(cdb_rob_tag), 64'(t));
    end
    tick();
    chk("s2_idle", 64'(cdb_valid), 64'(0));

    // Port 2 streams back-to-back.
    do_reset();
    for (int t = 1; t <= 4; t++) begin
      req_valid      = 4'b0100;
      req_rob_tag[2] = ROB_TAG_WIDTH'(t);
      req_data[2]    = XLEN'(32'h100 + t);
      #1;
      chk("s3_ready", 64'(req_ready[2]), 64'(1));
      tick();
      if (t >= 2) begin
        chk("s3_valid", 64'(cdb_valid), 64'(1));
        chk("s3_tag", 64'(cdb_rob_tag), 64'(t - 1));
      end
    end
    clr();
    tick();
    chk("s3_last_tag", 64'(cdb_rob_tag), 64'(4));
    chk("s3_last_data", 64'(cdb_data), 64'(32'h104));

    // Flush of tag 7 drops port 0; port 1's mispredict still goes out.
    do_reset();
    req_valid                = 4'b0011;
    req_rob_tag[0]           = 4'd7;
    req_data[0]              = 32'hDEAD_0007;
    req_rob_tag[1]           = 4'd6;
    req_data[1]              = 32'hBEEF_0006;
    req_branch_mispredict[1] = 1'b1;
    tick();
    clr();
    flush = 16'h0080;
    tick();
    flush = '0;
    chk("s4_valid", 64'(cdb_valid), 64'(1));
    chk("s4_tag", 64'(cdb_rob_tag), 64'(6));
    chk("s4_mis", 64'(branch_mispredict), 64'(1));
    chk("s4_held", 64'(held_valid), 64'(0));
    tick();
    chk("s4_no_tag7", 64'(cdb_valid), 64'(0));

    // Ports 3 and 0 held, pointer at 0 after reset: port 0 first, then port 3.
    do_reset();
    req_valid      = 4'b1001;
    req_rob_tag[0] = 4'd2;
    req_rob_tag[3] = 4'd9;
    tick();
    clr();
    tick();
    chk("s5_first", 64'(cdb_rob_tag), 64'(2));
    tick();
    chk("s5_second", 64'(cdb_rob_tag), 64'(9));

    // Reset while two ports hold entries: nothing is broadcast.
    do_reset();
    req_valid = 4'b0011;
    tick();
    clr();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s6_valid", 64'(cdb_valid), 64'(0));
    chk("s6_held", 64'(held_valid), 64'(0));
    tick();
    chk("s6_still_idle", 64'(cdb_valid), 64'(0));

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom % 300) == 0;
      req_valid = N_PORTS'($urandom);
      for (int q = 0; q < N_PORTS; q++) begin
        req_data[q]              = $urandom;
        req_rob_tag[q]           = ROB_TAG_WIDTH'($urandom);
        req_exception[q]         = ($urandom % 8) == 0;
        req_branch_mispredict[q] = ($urandom % 8) == 0;
      end
      flush = '0;
      if (($urandom % 3) == 0) flush[ROB_TAG_WIDTH'($urandom)] = 1'b1;
      if (($urandom % 7) == 0) flush[ROB_TAG_WIDTH'($urandom)] = 1'b1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
